// File: rtl/risc_pkg.sv
// Shared core constants for the integer pipeline: datapath widths, the indices of the
// write-back requesters, and the width of the arbiter's saturating wait counter.
package risc_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam int unsigned REQ_EX  = 0;
  localparam int unsigned REQ_LSU = 1;
  localparam int unsigned REQ_MDU = 2;

  localparam int unsigned WAIT_CNT_W = 3;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [WAIT_CNT_W-1:0] sat_inc(input logic [WAIT_CNT_W-1:0] c);
    return (&c) ? c : c + WAIT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/wb_arb_pick.sv
// Write-back grant selector. This block is purely combinational.
// An aged requester with the largest wait count wins, and on a tie the lowest index wins.
// If no requester is aged, the lowest valid index wins.
module wb_arb_pick
  import risc_pkg::*;
#(
  parameter int unsigned NREQ         = 3,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic [NREQ-1:0]            valid_i,
  input  logic [NREQ*WAIT_CNT_W-1:0] cnt_i,
  output logic [NREQ-1:0]            grant_o
);

  logic                  found_aged;
  logic                  found_fixed;
  logic [WAIT_CNT_W-1:0] best_cnt;
  logic [NREQ-1:0]       aged_gnt;
  logic [NREQ-1:0]       fixed_gnt;

  always_comb begin
    grant_o     = '0;
    found_aged  = 1'b0;
    found_fixed = 1'b0;
    best_cnt    = '0;
    aged_gnt    = '0;
    fixed_gnt   = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      // Strict '>' keeps the earlier (lower) index on equal counts.
      if (valid_i[i] && (32'(cnt_i[i*WAIT_CNT_W +: WAIT_CNT_W]) >= STARVE_LIMIT) &&
          (!found_aged || (cnt_i[i*WAIT_CNT_W +: WAIT_CNT_W] > best_cnt))) begin
        found_aged  = 1'b1;
        best_cnt    = cnt_i[i*WAIT_CNT_W +: WAIT_CNT_W];
        aged_gnt    = '0;
        aged_gnt[i] = 1'b1;
      end
      if (valid_i[i] && !found_fixed) begin
        found_fixed  = 1'b1;
        fixed_gnt[i] = 1'b1;
      end
    end
    grant_o = found_aged ? aged_gnt : fixed_gnt;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter. It accepts at most one requester per cycle.
// Grant selection is fixed priority with aging. The write port is driven from registers one cycle after acceptance.
module wb_arbiter
  import risc_pkg::*;
#(
  parameter int unsigned NREQ         = 3,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid_i,
  input  logic [NREQ*REG_ADDR_W-1:0] req_waddr_i,
  input  logic [NREQ*XLEN-1:0]       req_wdata_i,
  output logic [NREQ-1:0]            req_ready_o,
  input  logic                       hold_i,
  output logic                       reg_wen_o,
  output logic [REG_ADDR_W-1:0]      reg_waddr_o,
  output logic [XLEN-1:0]            reg_wdata_o
);

  logic [NREQ-1:0][WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0]                 pick_valid;
  logic [NREQ-1:0]                 grant;
  logic [NREQ-1:0]                 accept;
  logic                            xfer;
  logic [REG_ADDR_W-1:0]           sel_addr;
  logic [XLEN-1:0]                 sel_data;
  logic                            wen_q, wen_d;
  logic [REG_ADDR_W-1:0]           waddr_q, waddr_d;
  logic [XLEN-1:0]                 wdata_q, wdata_d;

  assign pick_valid = hold_i ? '0 : req_valid_i;

  wb_arb_pick #(
    .NREQ         (NREQ),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_pick (
    .valid_i (pick_valid),
    .cnt_i   (cnt_q),
    .grant_o (grant)
  );

  // Ready is gated by reset so that it drops asynchronously together with the state.
  assign req_ready_o = rst ? grant : '0;
  assign accept      = req_valid_i & req_ready_o;
  assign xfer        = |accept;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    cnt_d    = cnt_q;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (grant[i]) begin
        sel_addr = req_waddr_i[i*REG_ADDR_W +: REG_ADDR_W];
        sel_data = req_wdata_i[i*XLEN +: XLEN];
      end
      // Counters keep running during hold, so a requester's age is preserved across it.
      cnt_d[i] = (!req_valid_i[i] || accept[i]) ? '0 : sat_inc(cnt_q[i]);
    end
    wen_d   = xfer && (sel_addr != '0);
    waddr_d = xfer ? sel_addr : waddr_q;
    wdata_d = xfer ? sel_data : wdata_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign reg_wen_o   = wen_q;
  assign reg_waddr_o = waddr_q;
  assign reg_wdata_o = wdata_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter. Each accepted or idle cycle pushes the expected write-port state.
// That state is popped and compared one edge later.
module tb_wb_arbiter;
  import risc_pkg::*;

  localparam int unsigned NREQ = 3;

  typedef struct packed {
    logic        wen;
    logic [4:0]  addr;
    logic [31:0] data;
  } sb_t;

  logic             clk;
  logic             rst;
  logic [NREQ-1:0]  v;
  logic [4:0]       a [NREQ];
  logic [31:0]      d [NREQ];
  logic             hold;
  logic [NREQ-1:0]  req_ready_o;
  logic             reg_wen_o;
  logic [4:0]       reg_waddr_o;
  logic [31:0]      reg_wdata_o;

  sb_t         sb_q[$];
  logic [4:0]  last_addr;
  logic [31:0] last_data;
  int          checks;
  int          errors;

  wb_arbiter #(.NREQ(NREQ), .STARVE_LIMIT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (v),
    .req_waddr_i ({a[2], a[1], a[0]}),
    .req_wdata_i ({d[2], d[1], d[0]}),
    .req_ready_o (req_ready_o),
    .hold_i      (hold),
    .reg_wen_o   (reg_wen_o),
    .reg_waddr_o (reg_waddr_o),
    .reg_wdata_o (reg_wdata_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Check ready before the edge, push the expected result, clock once, then pop and compare.
  task automatic step(input logic [NREQ-1:0] exp_ready, input string name);
    sb_t exp;
    sb_t got;
    #1;
    checks++;
    if (req_ready_o !== exp_ready) begin
      errors++;
      $display("FAIL %s ready got %b exp %b", name, req_ready_o, exp_ready);
    end
    exp = '{wen: 1'b0, addr: last_addr, data: last_data};
    for (int i = 0; i < int'(NREQ); i++) begin
      if (exp_ready[i]) begin
        exp = '{wen: (a[i] != 5'd0), addr: a[i], data: d[i]};
        last_addr = a[i];
        last_data = d[i];
      end
    end
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    got = '{wen: reg_wen_o, addr: reg_waddr_o, data: reg_wdata_o};
    exp = sb_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s out got wen=%b a=%0d d=%h exp wen=%b a=%0d d=%h",
               name, got.wen, got.addr, got.data, exp.wen, exp.addr, exp.data);
    end
  endtask

  task automatic check_cnt(input int idx, input logic [2:0] exp, input string name);
    checks++;
    if (dut.cnt_q[idx] !== exp) begin
      errors++;
      $display("FAIL %s cnt[%0d] got %0d exp %0d", name, idx, dut.cnt_q[idx], exp);
    end
  endtask

  task automatic check_reset_state(input string name);
    checks++;
    if (reg_wen_o !== 1'b0 || reg_waddr_o !== 5'd0 || reg_wdata_o !== 32'd0 ||
        req_ready_o !== 3'b000) begin
      errors++;
      $display("FAIL %s got wen=%b a=%0d d=%h rdy=%b exp all zero",
               name, reg_wen_o, reg_waddr_o, reg_wdata_o, req_ready_o);
    end
    for (int i = 0; i < int'(NREQ); i++) check_cnt(i, 3'd0, name);
  endtask

  task automatic test_reset();
    rst  = 1'b0;
    hold = 1'b0;
    v    = 3'b111;
    for (int i = 0; i < int'(NREQ); i++) begin
      a[i] = 5'(i + 1);
      d[i] = 32'hA0 + 32'(i);
    end
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    v = 3'b000;
    last_addr = '0;
    last_data = '0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    v = 3'b001;
    a[REQ_EX] = 5'd3;
    d[REQ_EX] = 32'h1234;
    step(3'b001, "single_ex");
    v = 3'b000;
    step(3'b000, "single_idle");
  endtask

  task automatic test_two();
    v = 3'b011;
    a[REQ_EX]  = 5'd7;  d[REQ_EX]  = 32'h0000_0007;
    a[REQ_LSU] = 5'd9;  d[REQ_LSU] = 32'h0000_0009;
    step(3'b001, "two_ex");
    v = 3'b010;
    step(3'b010, "two_lsu");
    v = 3'b000;
    step(3'b000, "two_idle");
  endtask

  task automatic test_aging();
    v = 3'b101;
    a[REQ_MDU] = 5'd20;
    d[REQ_MDU] = 32'hDEAD_BEEF;
    for (int k = 1; k <= 4; k++) begin
      a[REQ_EX] = 5'(k);
      d[REQ_EX] = 32'(k) * 32'h111;
      step(3'b001, "aging_ex");
      check_cnt(REQ_MDU, 3'(k), "aging_cnt");
    end
    step(3'b100, "aging_mdu");
    v = 3'b001;
    a[REQ_EX] = 5'd11;
    d[REQ_EX] = 32'h0BAD_F00D;
    step(3'b001, "aging_resume");
    v = 3'b000;
    step(3'b000, "aging_idle");
  endtask

  task automatic test_x0();
    v = 3'b010;
    a[REQ_LSU] = 5'd0;
    d[REQ_LSU] = 32'hFFFF;
    step(3'b010, "x0_drop");
    v = 3'b000;
    step(3'b000, "x0_idle");
  endtask

  task automatic test_hold();
    hold = 1'b1;
    v = 3'b010;
    a[REQ_LSU] = 5'd5;
    d[REQ_LSU] = 32'h5555;
    repeat (3) step(3'b000, "hold_frozen");
    check_cnt(REQ_LSU, 3'd3, "hold_cnt");
    hold = 1'b0;
    step(3'b010, "hold_release");
    v = 3'b000;
    step(3'b000, "hold_idle");
  endtask

  task automatic test_back_to_back();
    // Grant order for three continuously valid requesters with STARVE_LIMIT = 4.
    logic [1:0] order [16] = '{0,0,0,0,1,2,0,0,0,1,2,0,0,0,1,2};
    int g;
    v = 3'b111;
    for (int i = 0; i < int'(NREQ); i++) begin
      a[i] = 5'(i + 1);
      d[i] = $urandom;
    end
    for (int n = 0; n < 16; n++) begin
      g = int'(order[n]);
      step(3'(1 << g), "b2b");
      a[g] = 5'((n * 3 + g) % 31 + 1);
      d[g] = $urandom;
    end
    v = 3'b000;
    step(3'b000, "b2b_idle");
  endtask

  task automatic test_reset_mid();
    v = 3'b011;
    a[REQ_EX] = 5'd14;
    d[REQ_EX] = 32'hCAFE_0001;
    a[REQ_LSU] = 5'd15;
    d[REQ_LSU] = 32'hCAFE_0002;
    step(3'b001, "mid_grant");
    check_cnt(REQ_LSU, 3'd1, "mid_pre_cnt");
    rst = 1'b0;
    #1;
    check_reset_state("mid_reset");
    last_addr = '0;
    last_data = '0;
    v = 3'b111;
    @(negedge clk);
    rst = 1'b1;
    step(3'b001, "first_grant");
    v = 3'b000;
    step(3'b000, "first_idle");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_two();
    test_aging();
    test_x0();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
